q_update_ctrl: RTL and testbench
================================

Name: q_update_ctrl

Overview:
Sequences one tabular Q-learning update per request: reads Q(s,a), scans every action of the next state s' for max Q, computes the shift-scaled update and writes the result back to the Q-table.
- Sits between the agent/environment interface and a single-port synchronous Q-table RAM.
- Owns the RAM port while busy.
- Gamma and alpha are power-of-two shift amounts, not multipliers.

Parameters:
N_STATES, 16, number of states (power of two)
N_ACTIONS, 4, actions per state (power of two, >=2)
QW, 16, Q-value and reward width, two's complement
AW, $clog2(N_STATES*N_ACTIONS), RAM address width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  update request; sampled only in IDLE
state_cur  in  $clog2(N_STATES)  s
action_cur  in  $clog2(N_ACTIONS)  a
state_next  in  $clog2(N_STATES)  s'
reward  in  QW  signed reward r
gamma  in  4  discount shift
alpha  in  4  learning-rate shift
busy  out  1  high from cycle after accepted start through the write cycle
done  out  1  one-cycle pulse, coincident with the write
new_q  out  QW  last written Q-value, held until next write
mem_addr  out  AW  RAM address = state*N_ACTIONS + action
mem_rd_en  out  1  read strobe
mem_rd_data  in  QW  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  write strobe
mem_wr_data  out  QW  write data

Behaviour:
- Reset: all outputs 0; FSM to IDLE.
- Inputs s, a, s', r, gamma and alpha are latched on the accepted start.
- FSM: IDLE -> READ -> DRAIN -> CALC -> WRITE -> IDLE.
- start in cycle 0 with FSM in IDLE is accepted.
- READ, cycles 1..N_ACTIONS+1:
  - Issues back-to-back reads.
  - First read is Q(s,a), captured as old_q.
  - Then Q(s',0)..Q(s',N_ACTIONS-1) in order.
- DRAIN, cycle N_ACTIONS+2: captures last read data.
- Max tracking: signed comparison; running max updated only on strictly greater, so a tie keeps the lowest action index.
- CALC, cycle N_ACTIONS+3: registers the result. All arithmetic is signed at QW+2 bits:
  - shifted = max_q >>> gamma
  - delta = r + shifted - old_q
  - upd = old_q + (delta >>> alpha)
  - Result is truncated to QW bits (two's-complement wrap).
  - gamma/alpha >= QW give 0 or -1 per arithmetic shift.
- WRITE, cycle N_ACTIONS+4: mem_wr_en=1, mem_addr=addr(s,a), mem_wr_data=new_q=result, done=1.
- busy drops the cycle after WRITE. With N_ACTIONS=4, start at cycle 0 gives write/done at cycle 8.
- start while busy: ignored and not queued. start in the WRITE cycle: ignored. start in the cycle after WRITE: accepted.
- mem_rd_en and mem_wr_en are never both high; mem_addr = 0 when both strobes are low.
- s' == s: allowed. The scan reads pre-update values, including Q(s,a).
- rst_n asserted mid-operation: immediate return to IDLE, no write issued, done not pulsed, new_q cleared to 0.

Optional Feature:
Q_SAT_EN
- Defined: the CALC result saturates to [-2^(QW-1), 2^(QW-1)-1] instead of wrapping.
- Undefined: truncation/wrap as above.
- FSM timing is identical in both cases.

Decomposition:
- Package q_learn_pkg: QW, state/action/address widths, FSM state enum, and an address-compose function (state*N_ACTIONS+action).
- Sub-module q_calc: purely combinational. Inputs old_q, max_q, reward, gamma, alpha; output result. Holds the saturation logic under Q_SAT_EN.
- The FSM, scan counter and max register stay in q_update_ctrl.

Test Plan:
- Basic update, N_ACTIONS=4, RAM zeroed:
  - Preload Q(2,1)=100 and Q(5,*)={10,128,-3,128}.
  - Start with s=2, a=1, s'=5, r=64, gamma=1, alpha=2.
  - Expected: max=128, delta=28, write Q(2,1)=107 at cycle 8; done pulse 1 cycle; new_q=107.
- Negative path: old=200, all Q(s')=0, r=-40, gamma=0, alpha=1 -> delta=-240, written 80.
- Overflow, alpha=0, gamma=0: old=32000, max=32767, r=32000.
  - Without Q_SAT_EN: writes -769.
  - With Q_SAT_EN: writes 32767.
  - Same cycle count in both.
- Protocol:
  - start pulsed during READ and during WRITE: exactly one write results.
  - start on the cycle after done: accepted, second write at +8 cycles.
  - mem_rd_en and mem_wr_en never overlap.
- Reset mid-operation: assert rst_n low during DRAIN.
  - Expected: no mem_wr_en, outputs 0, RAM unchanged.
  - A subsequent start completes normally.
- s'==s and max tie: Q(3,*)={7,9,9,-1}, s=s'=3, a=0, r=0, gamma=0, alpha=0.
  - Expected: max taken from action 1 (value 9), Q(3,0) written to 9.

Source files
------------

// File: rtl/q_learn_pkg.sv
`default_nettype none
// ============================================================================
// q_learn_pkg: shared widths, FSM encodings and RAM address helper.
// Revision: 1.0
// ============================================================================
package q_learn_pkg;

  localparam int N_STATES  = 16;
  localparam int N_ACTIONS = 4;
  localparam int QW        = 16;
  localparam int SW        = $clog2(N_STATES);
  localparam int ACW       = $clog2(N_ACTIONS);
  localparam int AW        = $clog2(N_STATES * N_ACTIONS);

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 3'd0;
  localparam fsm_state_t ST_READ  = 3'd1;
  localparam fsm_state_t ST_DRAIN = 3'd2;
  localparam fsm_state_t ST_CALC  = 3'd3;
  localparam fsm_state_t ST_WRITE = 3'd4;

  function automatic int unsigned q_addr(input int unsigned s,
                                         input int unsigned a,
                                         input int unsigned n_act);
    return s * n_act + a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// q_update_ctrl_if: agent request/response and Q-table RAM port bundle.
// Revision: 1.0
// ============================================================================
interface q_update_ctrl_if #(
  parameter int N_STATES  = 16,
  parameter int N_ACTIONS = 4,
  parameter int QW        = 16
);
  localparam int SW  = $clog2(N_STATES);
  localparam int ACW = $clog2(N_ACTIONS);
  localparam int AW  = $clog2(N_STATES * N_ACTIONS);

  logic           start;
  logic [SW-1:0]  state_cur;
  logic [ACW-1:0] action_cur;
  logic [SW-1:0]  state_next;
  logic [QW-1:0]  reward;
  logic [3:0]     gamma;
  logic [3:0]     alpha;
  logic           busy;
  logic           done;
  logic [QW-1:0]  new_q;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd_en;
  logic [QW-1:0]  mem_rd_data;
  logic           mem_wr_en;
  logic [QW-1:0]  mem_wr_data;

  modport master (
    output start, state_cur, action_cur, state_next, reward, gamma, alpha,
    input  busy, done, new_q,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );

  modport slave (
    input  start, state_cur, action_cur, state_next, reward, gamma, alpha,
    output busy, done, new_q,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/q_calc.sv
`default_nettype none
// ============================================================================
// q_calc: combinational shift-scaled Q update, wrap or saturate (Q_SAT_EN).
// Revision: 1.0
// ============================================================================
module q_calc #(
  parameter int QW = 16
) (
  input  wire logic signed [QW-1:0] old_q,
  input  wire logic signed [QW-1:0] max_q,
  input  wire logic signed [QW-1:0] reward,
  input  wire logic        [3:0]    gamma,
  input  wire logic        [3:0]    alpha,
  output logic             [QW-1:0] result
);
  localparam int EW = QW + 2;

  logic signed [EW-1:0] w_old;
  logic signed [EW-1:0] w_max;
  logic signed [EW-1:0] w_rew;
  logic signed [EW-1:0] w_shifted;
  logic signed [EW-1:0] w_delta;
  logic signed [EW-1:0] w_upd;

  assign w_old     = {{2{old_q[QW-1]}}, old_q};
  assign w_max     = {{2{max_q[QW-1]}}, max_q};
  assign w_rew     = {{2{reward[QW-1]}}, reward};
  assign w_shifted = w_max >>> gamma;
  assign w_delta   = w_rew + w_shifted - w_old;
  assign w_upd     = w_old + (w_delta >>> alpha);

`ifdef Q_SAT_EN
  // Out of range whenever the bits above the QW-bit sign are not all equal.
  logic w_ovf;
  assign w_ovf  = ~((&w_upd[EW-1:QW-1]) | ~(|w_upd[EW-1:QW-1]));
  assign result = w_ovf ? (w_upd[EW-1] ? {1'b1, {(QW-1){1'b0}}}
                                       : {1'b0, {(QW-1){1'b1}}})
                        : w_upd[QW-1:0];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_upd[EW-1:QW];
  assign result      = w_upd[QW-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/q_update_ctrl.sv
`default_nettype none
// ============================================================================
// q_update_ctrl: sequences one tabular Q-learning update per start request.
// Optional build macro: Q_SAT_EN (saturating result). Revision: 1.0
// ============================================================================
module q_update_ctrl
  import q_learn_pkg::*;
#(
  parameter int N_STATES  = q_learn_pkg::N_STATES,
  parameter int N_ACTIONS = q_learn_pkg::N_ACTIONS,
  parameter int QW        = q_learn_pkg::QW,
  parameter int AW        = $clog2(N_STATES * N_ACTIONS)
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  q_update_ctrl_if.slave  bus
);
  localparam int C_SW  = $clog2(N_STATES);
  localparam int C_ACW = $clog2(N_ACTIONS);
  localparam int C_IW  = $clog2(N_ACTIONS + 1);

  fsm_state_t              r_state;
  logic [C_IW-1:0]         r_idx;
  logic [C_SW-1:0]         r_s;
  logic [C_ACW-1:0]        r_a;
  logic [C_SW-1:0]         r_sn;
  logic signed [QW-1:0]    r_reward;
  logic [3:0]              r_gamma;
  logic [3:0]              r_alpha;
  logic signed [QW-1:0]    r_old_q;
  logic signed [QW-1:0]    r_max_q;
  logic                    r_pend;
  logic [C_IW-1:0]         r_pend_idx;
  logic [QW-1:0]           r_new_q;

  logic                    w_rd_en;
  logic                    w_wr_en;
  logic [AW-1:0]           w_addr;
  logic [QW-1:0]           w_result;
  logic signed [QW-1:0]    w_rd_q;

  assign w_rd_en = (r_state == ST_READ);
  assign w_wr_en = (r_state == ST_WRITE);
  assign w_rd_q  = $signed(bus.mem_rd_data);

  // Scan slot 0 is Q(s,a); slots 1..N_ACTIONS walk Q(s',0..N_ACTIONS-1).
  always_comb begin
    w_addr = '0;
    if (w_rd_en) begin
      if (r_idx == '0)
        w_addr = AW'(q_addr(32'(r_s), 32'(r_a), N_ACTIONS));
      else
        w_addr = AW'(q_addr(32'(r_sn), 32'(r_idx) - 32'd1, N_ACTIONS));
    end else if (w_wr_en) begin
      w_addr = AW'(q_addr(32'(r_s), 32'(r_a), N_ACTIONS));
    end
  end

  q_calc #(.QW(QW)) u_calc (
    .old_q  (r_old_q),
    .max_q  (r_max_q),
    .reward (r_reward),
    .gamma  (r_gamma),
    .alpha  (r_alpha),
    .result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_s        <= '0;
      r_a        <= '0;
      r_sn       <= '0;
      r_reward   <= '0;
      r_gamma    <= '0;
      r_alpha    <= '0;
      r_old_q    <= '0;
      r_max_q    <= '0;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      r_new_q    <= '0;
    end else begin
      r_pend     <= w_rd_en;
      r_pend_idx <= r_idx;

      // Read data lands one cycle after its strobe, tagged by the delayed slot.
      if (r_pend) begin
        if (r_pend_idx == '0)
          r_old_q <= w_rd_q;
        else if (r_pend_idx == C_IW'(1) || w_rd_q > r_max_q)
          r_max_q <= w_rd_q;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_s      <= bus.state_cur;
            r_a      <= bus.action_cur;
            r_sn     <= bus.state_next;
            r_reward <= $signed(bus.reward);
            r_gamma  <= bus.gamma;
            r_alpha  <= bus.alpha;
            r_idx    <= '0;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (r_idx == C_IW'(N_ACTIONS))
            r_state <= ST_DRAIN;
          else
            r_idx <= r_idx + C_IW'(1);
        end
        ST_DRAIN: r_state <= ST_CALC;
        ST_CALC: begin
          r_new_q <= w_result;
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = w_wr_en;
  assign bus.new_q       = r_new_q;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_wr_en   = w_wr_en;
  assign bus.mem_wr_data = w_wr_en ? r_new_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_q_update_ctrl.sv
`default_nettype none
// ============================================================================
// tb_q_update_ctrl: randomized and directed checks against a Q-update model.
// Revision: 1.0
// ============================================================================
module tb_q_update_ctrl;
  localparam int NS  = 16;
  localparam int NA  = 4;
  localparam int QW  = 16;
  localparam int SW  = 4;
  localparam int ACW = 2;
  localparam int AW  = 6;
  localparam int LAT = NA + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q_update_ctrl_if #(.N_STATES(NS), .N_ACTIONS(NA), .QW(QW)) bus ();

  q_update_ctrl #(.N_STATES(NS), .N_ACTIONS(NA), .QW(QW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [QW-1:0] ram [NS*NA] = '{default: '0};
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [QW-1:0] bd_data = '0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int overlap = 0;
  int stray_addr = 0;

  // Synchronous RAM with one-cycle read latency plus a backdoor preload port.
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    else if (bd_en)    ram[bd_addr] <= bd_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
    if (bus.mem_wr_en) wr_count <= wr_count + 1;
    if (bus.mem_rd_en && bus.mem_wr_en) overlap <= overlap + 1;
    if (!bus.mem_rd_en && !bus.mem_wr_en && bus.mem_addr != '0) stray_addr <= stray_addr + 1;
  end

  function automatic int sx(input logic [QW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int model_q(input int old, input int mx, input int r, input int g, input int al);
    int d;
    int u;
    d = r + (mx >>> g) - old;
    u = old + (d >>> al);
`ifdef Q_SAT_EN
    if (u > 32767) u = 32767;
    else if (u < -32768) u = -32768;
`else
    u = sx(QW'(u));
`endif
    return u;
  endfunction

  function automatic int model_max(input int sn);
    int m;
    m = sx(ram[sn*NA]);
    for (int k = 1; k < NA; k++)
      if (sx(ram[sn*NA+k]) > m) m = sx(ram[sn*NA+k]);
    return m;
  endfunction

  task automatic ram_put(input int addr, input int data);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = AW'(addr); bd_data = QW'(data);
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic drive_req(input int s, input int a, input int sn, input int r, input int g, input int al);
    bus.state_cur = SW'(s); bus.action_cur = ACW'(a); bus.state_next = SW'(sn);
    bus.reward = QW'(r); bus.gamma = 4'(g); bus.alpha = 4'(al);
  endtask

  // Issues one request and returns the model result plus what the DUT wrote.
  task automatic run_update(input int s, input int a, input int sn, input int r, input int g, input int al,
                            output int exp, output int cyc, output logic [QW-1:0] wdata,
                            output logic [AW-1:0] waddr, output logic wen);
    @(negedge clk);
    exp = model_q(sx(ram[s*NA+a]), model_max(sn), r, g, al);
    drive_req(s, a, sn, r, g, al);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    wdata = bus.mem_wr_data; waddr = bus.mem_addr; wen = bus.mem_wr_en;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.new_q !== '0) begin
      errors++; $display("FAIL reset_new_q got %0h exp 0", bus.new_q);
    end
    checks++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_mem got rd=%b wr=%b addr=%0d exp all 0", bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int exp, cyc; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    ram_put(2*NA+1, 100);
    ram_put(5*NA+0, 10); ram_put(5*NA+1, 128); ram_put(5*NA+2, -3); ram_put(5*NA+3, 128);
    run_update(2, 1, 5, 64, 1, 2, exp, cyc, wd, wa, we);
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, LAT); end
    checks++;
    if (sx(wd) != 107 || wa != AW'(9) || we !== 1'b1) begin
      errors++; $display("FAIL basic_write got data=%0d addr=%0d we=%b exp 107 9 1", sx(wd), wa, we);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || sx(bus.new_q) != 107) begin
      errors++; $display("FAIL basic_after got done=%b busy=%b new_q=%0d exp 0 0 107", bus.done, bus.busy, sx(bus.new_q));
    end
  endtask

  task automatic test_negative();
    int exp, cyc; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    ram_put(1*NA+2, 200);
    run_update(1, 2, 7, -40, 0, 1, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != 80 || cyc != LAT) begin
      errors++; $display("FAIL negative got data=%0d cyc=%0d exp 80 %0d", sx(wd), cyc, LAT);
    end
  endtask

  task automatic test_overflow();
    int exp, cyc, want; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
`ifdef Q_SAT_EN
    want = 32767;
`else
    want = -769;
`endif
    ram_put(4*NA+0, 32000);
    ram_put(6*NA+0, 32767);
    run_update(4, 0, 6, 32000, 0, 0, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != want || cyc != LAT) begin
      errors++; $display("FAIL overflow got data=%0d cyc=%0d exp %0d %0d", sx(wd), cyc, want, LAT);
    end
  endtask

  task automatic test_tie_same_state();
    int exp, cyc; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    ram_put(3*NA+0, 7); ram_put(3*NA+1, 9); ram_put(3*NA+2, 9); ram_put(3*NA+3, -1);
    run_update(3, 0, 3, 0, 0, 0, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != 9 || wa != AW'(12)) begin
      errors++; $display("FAIL tie_write got data=%0d addr=%0d exp 9 12", sx(wd), wa);
    end
    @(negedge clk);
    checks++;
    if (sx(ram[12]) != 9) begin errors++; $display("FAIL tie_ram got %0d exp 9", sx(ram[12])); end
  endtask

  task automatic test_start_ignored();
    int cyc, wc0;
    @(negedge clk);
    wc0 = wr_count;
    drive_req(0, 0, 1, 5, 0, 0);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 3;
    while (bus.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", cyc, LAT); end
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_count - wc0 != 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_writes got %0d busy=%b exp 1 0", wr_count - wc0, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp, cyc; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    ram_put(9*NA+2, 500); ram_put(10*NA+0, 300);
    run_update(9, 2, 10, 100, 1, 1, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != exp || cyc != LAT) begin
      errors++; $display("FAIL b2b_first got data=%0d cyc=%0d exp %0d %0d", sx(wd), cyc, exp, LAT);
    end
    // The second request depends on the value just written.
    run_update(9, 2, 10, -60, 2, 0, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != exp || cyc != LAT) begin
      errors++; $display("FAIL b2b_second got data=%0d cyc=%0d exp %0d %0d", sx(wd), cyc, exp, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int exp, cyc, wc0; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    ram_put(6*NA+3, 1234);
    @(negedge clk);
    wc0 = wr_count;
    drive_req(6, 3, 2, 999, 0, 0);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (NA + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0 || bus.new_q !== '0 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b done=%b new_q=%0d exp 0 0 0", bus.busy, bus.done, sx(bus.new_q));
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_count != wc0 || sx(ram[6*NA+3]) != 1234) begin
      errors++; $display("FAIL midrst_nowrite got writes=%0d ram=%0d exp 0 1234", wr_count - wc0, sx(ram[6*NA+3]));
    end
    run_update(6, 3, 2, 999, 0, 0, exp, cyc, wd, wa, we);
    checks++;
    if (sx(wd) != exp || cyc != LAT || wa != AW'(6*NA+3)) begin
      errors++; $display("FAIL midrst_recover got data=%0d cyc=%0d addr=%0d exp %0d %0d %0d", sx(wd), cyc, wa, exp, LAT, 6*NA+3);
    end
  endtask

  task automatic test_random();
    int exp, cyc, s, a, sn, r, g, al; logic [QW-1:0] wd; logic [AW-1:0] wa; logic we;
    for (int it = 0; it < 40; it++) begin
      s  = int'($urandom_range(0, NS-1));
      a  = int'($urandom_range(0, NA-1));
      sn = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, NS-1));
      ram_put(s*NA+a, int'($urandom_range(0, 65535)));
      for (int k = 0; k < NA; k++)
        if ($urandom_range(0, 3) == 0)
          ram_put(sn*NA+k, int'($urandom_range(32000, 32767)));
        else
          ram_put(sn*NA+k, int'($urandom_range(0, 65535)));
      r  = sx(QW'($urandom_range(0, 65535)));
      g  = int'($urandom_range(0, 15));
      al = int'($urandom_range(0, 15));
      run_update(s, a, sn, r, g, al, exp, cyc, wd, wa, we);
      checks++;
      if (sx(wd) != exp || cyc != LAT || wa != AW'(s*NA+a) || we !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] got data=%0d cyc=%0d addr=%0d exp %0d %0d %0d", it, sx(wd), cyc, wa, exp, LAT, s*NA+a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_tie_same_state();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(negedge clk);
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap); end
    checks++;
    if (stray_addr != 0) begin errors++; $display("FAIL idle_addr got %0d exp 0", stray_addr); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
